// File: rtl/node_patch_pkg.sv
// Shared definitions for the 4x4 wave-equation node patch: fixed-point
// widths, grid geometry, the node value type and sign-extension helpers.
package node_patch_pkg;

  // 18-bit signed values with 17 fraction bits: 0x20000 = -1.0, 0x1FFFF ~ +1.0
  localparam int NODE_W   = 18;
  localparam int FRAC_W   = 17;
  localparam int NODE_CNT = 16;
  localparam int GRID_DIM = 4;

  // Laplacian sum and the time-step expression are carried at 21 bits
  localparam int SUM_W  = 21;
  // The centre-average sum of four nodes is carried at 20 bits
  localparam int AVG_W  = 20;
  // rho (18 bits) times S (21 bits)
  localparam int PROD_W = SUM_W + NODE_W;

  // Node indices of the 2x2 centre block, index = row*4 + col
  localparam int CENTRE_NW = 5;
  localparam int CENTRE_NE = 6;
  localparam int CENTRE_SW = 9;
  localparam int CENTRE_SE = 10;

  typedef logic signed [NODE_W-1:0] node_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [AVG_W-1:0]  avg_t;

  // Sign-extend a node value to the 21-bit arithmetic width
  function automatic sum_t widen_sum(node_t v);
    return {{(SUM_W-NODE_W){v[NODE_W-1]}}, v};
  endfunction

  // Sign-extend a node value to the 20-bit centre-average width
  function automatic avg_t widen_avg(node_t v);
    return {{(AVG_W-NODE_W){v[NODE_W-1]}}, v};
  endfunction

endpackage

// File: rtl/four_by_four_node_patch_node_update.sv
// Per-node time-step arithmetic for the damped discrete wave equation.
// Purely combinational: next u from u, previous u, four neighbours and rho.
// Macro NODE_PATCH_SAT_EN selects saturation of the 18-bit result;
// without it the result wraps (low 18 bits kept).
module node_update
  import node_patch_pkg::*;
#(
  parameter int DAMP_SHIFT = 10
) (
  input  node_t i_u,
  input  node_t i_up,
  input  node_t i_left,
  input  node_t i_right,
  input  node_t i_top,
  input  node_t i_bottom,
  input  node_t i_rho,
  output node_t o_next
);

  sum_t w_u;
  sum_t w_up;
  sum_t w_s;
  sum_t w_m;
  sum_t w_t;
  sum_t w_n;

  logic signed [PROD_W-1:0] w_rho_x;
  logic signed [PROD_W-1:0] w_s_x;
  logic signed [PROD_W-1:0] w_prod;

  assign w_u  = widen_sum(i_u);
  assign w_up = widen_sum(i_up);

  // Discrete Laplacian: neighbours minus 4u, wraps at 21 bits
  assign w_s = widen_sum(i_left) + widen_sum(i_right)
             + widen_sum(i_top)  + widen_sum(i_bottom)
             - (w_u <<< 2);

  // Full-width signed product so the arithmetic shift sees the true sign
  assign w_rho_x = {{(PROD_W-NODE_W){i_rho[NODE_W-1]}}, i_rho};
  assign w_s_x   = {{(PROD_W-SUM_W){w_s[SUM_W-1]}}, w_s};
  assign w_prod  = w_rho_x * w_s_x;

  // Back to fixed point, then keep 21 bits for the time-step sum
  assign w_m = sum_t'(w_prod >>> FRAC_W);

  // Leapfrog step: M + 2u - up
  assign w_t = w_m + (w_u <<< 1) - w_up;

  // Damping removes T/2^DAMP_SHIFT each step; cannot overflow because the
  // subtracted term has the same sign and smaller magnitude than T
  assign w_n = w_t - (w_t >>> DAMP_SHIFT);

`ifdef NODE_PATCH_SAT_EN
  localparam sum_t SAT_MAX = sum_t'(131071);
  localparam sum_t SAT_MIN = sum_t'(-131072);

  // Clamp the 21-bit result into the representable 18-bit range
  always_comb begin
    o_next = node_t'(w_n);
    if (w_n > SAT_MAX) begin
      o_next = node_t'(SAT_MAX);
    end else if (w_n < SAT_MIN) begin
      o_next = node_t'(SAT_MIN);
    end
  end
`else
  // Two's-complement wrap: keep the low 18 bits
  always_comb begin
    o_next = node_t'(w_n);
  end
`endif

endmodule

// File: rtl/four_by_four_node_patch.sv
// 4x4 patch of wave-equation nodes. Each enabled cycle advances all 16
// nodes one time step in parallel; edge nodes take their missing
// neighbour from the adjacent-patch boundary inputs. data_out is the
// centre 2x2 average (middle=0) or node 10 (middle=1).
// Optional macro NODE_PATCH_SAT_EN: saturate node updates instead of wrapping.
module four_by_four_node_patch
  import node_patch_pkg::*;
#(
  parameter int DAMP_SHIFT = 10
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  enable,
  input  logic  middle,
  input  node_t init [NODE_CNT],
  input  node_t u_1_right,
  input  node_t u_1_left_1,
  input  node_t u_1_up_1,
  input  node_t u_1_down_1,
  input  node_t rho,
  output node_t data_out
);

  // Current and previous value of every node
  node_t r_u  [NODE_CNT];
  node_t r_up [NODE_CNT];

  // Neighbour selection and next-step values
  node_t w_left   [NODE_CNT];
  node_t w_right  [NODE_CNT];
  node_t w_top    [NODE_CNT];
  node_t w_bottom [NODE_CNT];
  node_t w_next   [NODE_CNT];

  avg_t w_centre_sum;

  for (genvar k = 0; k < NODE_CNT; k++) begin : gen_node
    localparam int ROW = k / GRID_DIM;
    localparam int COL = k % GRID_DIM;

    if (COL == 0) begin : gen_left_edge
      assign w_left[k] = u_1_left_1;
    end else begin : gen_left_inner
      assign w_left[k] = r_u[k-1];
    end

    if (COL == GRID_DIM-1) begin : gen_right_edge
      assign w_right[k] = u_1_right;
    end else begin : gen_right_inner
      assign w_right[k] = r_u[k+1];
    end

    if (ROW == 0) begin : gen_top_edge
      assign w_top[k] = u_1_up_1;
    end else begin : gen_top_inner
      assign w_top[k] = r_u[k-GRID_DIM];
    end

    if (ROW == GRID_DIM-1) begin : gen_bottom_edge
      assign w_bottom[k] = u_1_down_1;
    end else begin : gen_bottom_inner
      assign w_bottom[k] = r_u[k+GRID_DIM];
    end

    node_update #(
      .DAMP_SHIFT (DAMP_SHIFT)
    ) u_node_update (
      .i_u      (r_u[k]),
      .i_up     (r_up[k]),
      .i_left   (w_left[k]),
      .i_right  (w_right[k]),
      .i_top    (w_top[k]),
      .i_bottom (w_bottom[k]),
      .i_rho    (rho),
      .o_next   (w_next[k])
    );
  end

  // Reset loads init with zero velocity; enable advances every node at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NODE_CNT; k++) begin
        r_u[k]  <= init[k];
        r_up[k] <= init[k];
      end
    end else if (enable) begin
      for (int k = 0; k < NODE_CNT; k++) begin
        r_up[k] <= r_u[k];
        r_u[k]  <= w_next[k];
      end
    end
  end

  // Centre 2x2 sum cannot overflow 20 bits (4 * 18-bit values)
  assign w_centre_sum = widen_avg(r_u[CENTRE_NW]) + widen_avg(r_u[CENTRE_NE])
                      + widen_avg(r_u[CENTRE_SW]) + widen_avg(r_u[CENTRE_SE]);

  // Summary output: centre average or the single centre node 10
  always_comb begin
    data_out = node_t'(w_centre_sum >>> 2);
    if (middle) begin
      data_out = r_u[CENTRE_SE];
    end
  end

endmodule

// File: tb/tb_four_by_four_node_patch.sv
// Self-checking bench for four_by_four_node_patch. A longint reference
// model of the wave-equation patch is stepped alongside the design and
// compared with data_out and every node on each falling edge; directed
// scenarios add hand-computed literal expectations.
// Handshake note: the design has no valid/ready handshake; enable is a
// plain per-cycle advance qualifier sampled on the rising edge.
module tb_four_by_four_node_patch;
  import node_patch_pkg::*;

  localparam int DAMP = 10;

  logic  clock;
  logic  reset;
  logic  enable;
  logic  middle;
  node_t init [NODE_CNT];
  node_t u_1_right;
  node_t u_1_left_1;
  node_t u_1_up_1;
  node_t u_1_down_1;
  node_t rho;
  node_t data_out;

  int n_checks;
  int n_errors;
  bit chk_on;

  longint m_u  [NODE_CNT];
  longint m_up [NODE_CNT];

  four_by_four_node_patch #(
    .DAMP_SHIFT (DAMP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .middle     (middle),
    .init       (init),
    .u_1_right  (u_1_right),
    .u_1_left_1 (u_1_left_1),
    .u_1_up_1   (u_1_up_1),
    .u_1_down_1 (u_1_down_1),
    .rho        (rho),
    .data_out   (data_out)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  function automatic longint wrap(longint x, int b);
    longint span;
    longint v;
    span = longint'(1) << b;
    v = x & (span - 1);
    if (v >= (span >> 1)) v = v - span;
    return v;
  endfunction

  function automatic longint reduce18(longint n);
`ifdef NODE_PATCH_SAT_EN
    if (n > 131071) return 131071;
    if (n < -131072) return -131072;
    return n;
`else
    return wrap(n, 18);
`endif
  endfunction

  function automatic logic [17:0] to18(longint x);
    return x[17:0];
  endfunction

  task automatic model_load();
    for (int k = 0; k < NODE_CNT; k++) begin
      m_u[k]  = longint'(init[k]);
      m_up[k] = longint'(init[k]);
    end
  endtask

  task automatic model_step();
    longint nxt [NODE_CNT];
    longint l, r, t, d, s, m, tt, n;
    for (int k = 0; k < NODE_CNT; k++) begin
      if (k % 4 == 0) l = longint'(u_1_left_1); else l = m_u[k-1];
      if (k % 4 == 3) r = longint'(u_1_right);  else r = m_u[k+1];
      if (k / 4 == 0) t = longint'(u_1_up_1);   else t = m_u[k-4];
      if (k / 4 == 3) d = longint'(u_1_down_1); else d = m_u[k+4];
      s  = wrap(l + r + t + d - 4 * m_u[k], 21);
      m  = (longint'(rho) * s) >>> 17;
      tt = wrap(m + 2 * m_u[k] - m_up[k], 21);
      n  = tt - (tt >>> DAMP);
      nxt[k] = reduce18(n);
    end
    for (int k = 0; k < NODE_CNT; k++) begin
      m_up[k] = m_u[k];
      m_u[k]  = nxt[k];
    end
  endtask

  function automatic longint model_out();
    if (middle) return m_u[10];
    return (m_u[5] + m_u[6] + m_u[9] + m_u[10]) >>> 2;
  endfunction

  // Model advances on the same edges as the design
  always @(posedge clock) begin
    if (reset && enable) model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  // Compare process: every falling edge, output and all nodes vs the model
  always @(negedge clock) begin
    if (chk_on) begin
      check("data_out", data_out, to18(model_out()));
      for (int k = 0; k < NODE_CNT; k++) begin
        check($sformatf("node_u%0d", k), dut.r_u[k], to18(m_u[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(logic en);
    @(negedge clock);
    #1;
    enable = en;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_low();
    @(negedge clock);
    #1;
    reset = 1'b0;
    model_load();
    #1;
  endtask

  task automatic reset_high();
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NODE_CNT; k++) init[k] = '0;
    u_1_right  = '0;
    u_1_left_1 = '0;
    u_1_up_1   = '0;
    u_1_down_1 = '0;
    rho        = 18'h02000;
    middle     = 1'b0;
    enable     = 1'b0;
  endtask

  task automatic rand_cycle();
    @(negedge clock);
    #1;
    u_1_right  = node_t'($urandom);
    u_1_left_1 = node_t'($urandom);
    u_1_up_1   = node_t'($urandom);
    u_1_down_1 = node_t'($urandom);
    middle     = 1'($urandom_range(0, 1));
    enable     = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 59) == 0) begin
      reset = 1'b0;
      model_load();
    end else begin
      reset = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    chk_on   = 1'b0;
    clear_inputs();
    reset = 1'b0;
    model_load();
    #2;
    chk_on = 1'b1;
    check("reset_zero", data_out, 18'h00000);
    reset_high();

    // Quiet field stays at zero
    enable = 1'b1;
    for (int i = 0; i < 100; i++) cycle(1'b1);
    check("zero_field_100", data_out, 18'h00000);

    // Single bump at node 5
    clear_inputs();
    init[5] = 18'h08000;
    reset_low();
    check("bump_reset_out", data_out, 18'h02000);
    reset_high();
    cycle(1'b1);
    check("bump_u5", dut.r_u[5], 18'h05FE8);
    check("bump_u6", dut.r_u[6], 18'h007FE);
    check("bump_u9", dut.r_u[9], 18'h007FE);
    check("bump_u10", dut.r_u[10], 18'h00000);
    check("bump_out", data_out, 18'h01BF9);
    check("model_u5", to18(m_u[5]), 18'h05FE8);
    check("model_u6", to18(m_u[6]), 18'h007FE);
    middle = 1'b1;
    #1;
    check("bump_middle_out", data_out, 18'h00000);
    middle = 1'b0;
    #1;

    // Hold with enable low
    for (int i = 0; i < 10; i++) cycle(1'b0);
    check("hold_u5", dut.r_u[5], 18'h05FE8);
    check("hold_u6", dut.r_u[6], 18'h007FE);
    check("hold_out", data_out, 18'h01BF9);

    // Reset between edges restores init immediately
    @(posedge clock);
    #3;
    reset = 1'b0;
    model_load();
    #1;
    check("async_reset_out", data_out, 18'h02000);
    check("async_reset_u5", dut.r_u[5], 18'h08000);
    reset_high();

    // Right boundary drive
    clear_inputs();
    u_1_right = 18'h10000;
    reset_low();
    reset_high();
    cycle(1'b1);
    for (int k = 0; k < NODE_CNT; k++) begin
      check($sformatf("right_u%0d", k), dut.r_u[k],
            (k % 4 == 3) ? 18'h00FFC : 18'h00000);
    end
    check("right_out", data_out, 18'h00000);
    check("model_right_u3", to18(m_u[3]), 18'h00FFC);

    // Overflow corner: node 0 driven hard from top and left
    clear_inputs();
    rho        = 18'h1FFFF;
    u_1_up_1   = 18'h1FFFF;
    u_1_left_1 = 18'h1FFFF;
    reset_low();
    reset_high();
    cycle(1'b1);
`ifdef NODE_PATCH_SAT_EN
    check("corner_u0", dut.r_u[0], 18'h1FFFF);
    check("model_corner_u0", to18(m_u[0]), 18'h1FFFF);
`else
    check("corner_u0", dut.r_u[0], 18'h3FEFD);
    check("model_corner_u0", to18(m_u[0]), 18'h3FEFD);
`endif

    // Randomised episodes against the model
    for (int ep = 0; ep < 6; ep++) begin
      clear_inputs();
      for (int k = 0; k < NODE_CNT; k++) begin
        if (ep % 2 == 0) init[k] = node_t'(int'($urandom_range(0, 16383)) - 8192);
        else             init[k] = node_t'($urandom);
      end
      if (ep % 2 == 0) rho = node_t'($urandom_range(0, 18'h04000));
      else             rho = node_t'($urandom);
      reset_low();
      reset_high();
      for (int i = 0; i < 150; i++) rand_cycle();
      reset_high();
    end

    @(negedge clock);
    #1;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
